// File: rtl/box_move_scheduler.sv
// Turns four raw direction buttons into frame-synchronous, single-cycle move codes
// with debounce, opposite-direction cancel, round-robin arbitration and auto-repeat.
module box_move_scheduler #(
    parameter int unsigned DEB_CYCLES   = 1000000,
    parameter int unsigned REPEAT_DELAY = 30,
    parameter int unsigned REPEAT_RATE  = 4,
    parameter bit          VSYNC_POL    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       vsync,
    output logic [2:0] swout,
    output logic       active
);

    localparam int unsigned DW   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LD = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_LD  = CW'(REPEAT_RATE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [3:0]    deb_q;
    logic [DW-1:0] deb_cnt_q [4];

    logic          vs_q;
    logic          vs_d;
    logic          tick;

    logic [3:0]    elig;
    logic          any_elig;
    logic [1:0]    grant;
    logic [1:0]    scan;
    logic          found;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    last_q;
    logic [2:0]    swout_q;
    logic          active_q;

    // Two-flop synchroniser per button bit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // A level is accepted only after DEB_CYCLES consecutive cycles differing from the stable value.
    // NOTE: the counter array is reset explicitly; it is control state, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Frame tick: first cycle of the active vsync level.
    assign vs_d = (vsync == VSYNC_POL);
    assign tick = vs_d & ~vs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vs_d;
        end
    end

    // Opposite directions held together cancel each other.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        elig = deb_q;
        if (deb_q[0] && deb_q[2]) begin
            elig[0] = 1'b0;
            elig[2] = 1'b0;
        end
        if (deb_q[1] && deb_q[3]) begin
            elig[1] = 1'b0;
            elig[3] = 1'b0;
        end
    end

    assign any_elig = |elig;

    // Round-robin: first eligible direction after the last issued one, wrapping.
    always_comb begin
        grant = last_q;
        found = 1'b0;
        scan  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            scan = last_q + 2'(k);
            if (!found && elig[scan]) begin
                grant = scan;
                found = 1'b1;
            end
        end
    end

    // Move pacing FSM; a release always beats a same-cycle tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 2'd3;
            swout_q  <= 3'd0;
            active_q <= 1'b0;
        end else begin
            swout_q <= 3'd0;
            case (state_q)
                S_IDLE: begin
                    if (tick && any_elig) begin
                        swout_q  <= {1'b0, grant} + 3'd1;
                        last_q   <= grant;
                        cnt_q    <= DELAY_LD;
                        state_q  <= S_DELAY;
                        active_q <= 1'b1;
                    end
                end
                S_DELAY, S_REPEAT: begin
                    if (!any_elig) begin
                        state_q  <= S_IDLE;
                        cnt_q    <= '0;
                        active_q <= 1'b0;
                    end else if (tick) begin
                        if (cnt_q == CNT_ONE) begin
                            swout_q <= {1'b0, grant} + 3'd1;
                            last_q  <= grant;
                            cnt_q   <= RATE_LD;
                            state_q <= S_REPEAT;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    cnt_q    <= '0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign swout  = swout_q;
    assign active = active_q;

endmodule

// File: tb/tb_box_move_scheduler.sv
// Self-checking bench: directed scenarios plus random button activity, compared every
// cycle against a frame-counting behavioural model of the scheduler.
module tb_box_move_scheduler;

    localparam int DEB   = 4;
    localparam int DLY   = 3;
    localparam int RATE  = 2;
    localparam int FRAME = 100;
    localparam int HN    = DEB + 2;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic       vsync;
    logic [2:0] swout;
    logic       active;

    logic       vs_manual;
    logic       vs_man_val;
    logic       vs_auto;
    int         fcyc;
    int         frame_no;

    int total;
    int bad;

    typedef struct {
        int frame;
        int code;
    } mv_t;
    mv_t log_q[$];
    logic [2:0] prev_sw;
    logic       act_seen;

    // Behavioural model state
    logic [3:0] raw [HN];
    logic [3:0] m_deb;
    logic       m_prev_vs;
    logic       m_hold;
    int         m_frames;
    int         m_last;
    logic [2:0] exp_swout;
    logic       exp_active;

    assign vsync = vs_manual ? vs_man_val : vs_auto;

    box_move_scheduler #(
        .DEB_CYCLES  (DEB),
        .REPEAT_DELAY(DLY),
        .REPEAT_RATE (RATE),
        .VSYNC_POL   (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .vsync (vsync),
        .swout (swout),
        .active(active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame generator: vsync active for the first 10 cycles of every 100-cycle frame.
    initial begin
        fcyc     = FRAME - 1;
        frame_no = 0;
        vs_auto  = 1'b0;
        forever begin
            @(negedge clk);
            fcyc = (fcyc == FRAME - 1) ? 0 : fcyc + 1;
            if (fcyc == 0) frame_no++;
            vs_auto = (fcyc < 10);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] cancel(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[0] && d[2]) begin r[0] = 1'b0; r[2] = 1'b0; end
        if (d[1] && d[3]) begin r[1] = 1'b0; r[3] = 1'b0; end
        return r;
    endfunction

    // Model: a button counts as pressed once its last DEB synchronised samples all disagree
    // with the stable level; moves fall on tick 0, tick DLY, then every RATE ticks of a hold.
    always @(posedge clk) begin : model
        logic [3:0] e;
        logic       tk;
        logic       issue;
        logic       flip;
        int         pick;
        int         d;
        if (rst) begin
            for (int i = 0; i < HN; i++) raw[i] = 4'b0000;
            m_deb      = 4'b0000;
            m_prev_vs  = 1'b0;
            m_hold     = 1'b0;
            m_frames   = 0;
            m_last     = 3;
            exp_swout  = 3'd0;
            exp_active = 1'b0;
        end else begin
            e         = cancel(m_deb);
            tk        = vsync && !m_prev_vs;
            m_prev_vs = vsync;
            issue     = 1'b0;
            if (!m_hold) begin
                if (tk && e != 4'b0000) begin
                    issue    = 1'b1;
                    m_hold   = 1'b1;
                    m_frames = 0;
                end
            end else if (e == 4'b0000) begin
                m_hold = 1'b0;
            end else if (tk) begin
                m_frames++;
                if (m_frames == DLY || (m_frames > DLY && (m_frames - DLY) % RATE == 0))
                    issue = 1'b1;
            end
            exp_swout = 3'd0;
            if (issue) begin
                pick = -1;
                for (int k = 1; k <= 4; k++) begin
                    d = (m_last + k) % 4;
                    if (pick < 0 && e[d]) pick = d;
                end
                exp_swout = 3'(pick + 1);
                m_last    = pick;
            end
            exp_active = m_hold;
            for (int i = HN - 1; i > 0; i--) raw[i] = raw[i-1];
            raw[0] = btn;
            for (int b = 0; b < 4; b++) begin
                flip = 1'b1;
                for (int j = 2; j < HN; j++) if (raw[j][b] == m_deb[b]) flip = 1'b0;
                if (flip) m_deb[b] = ~m_deb[b];
            end
        end
    end

    // Compare process: every cycle, a few time units after the edge.
    initial begin
        prev_sw  = 3'd0;
        act_seen = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            check("swout", {29'd0, swout}, {29'd0, exp_swout});
            check("active", {31'd0, active}, {31'd0, exp_active});
            check("back_to_back", {31'd0, (swout != 3'd0 && prev_sw != 3'd0)}, 32'd0);
            prev_sw = swout;
            if (active === 1'b1) act_seen = 1'b1;
            if (swout != 3'd0) log_q.push_back('{frame: frame_no, code: int'(swout)});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_mid();
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (fcyc != 50 && n < 3 * FRAME);
        check("frame_align", fcyc, 50);
    endtask

    task automatic check_log(input string name, input int idx, input int frame, input int code);
        check({name, "_frame"}, (idx < log_q.size()) ? log_q[idx].frame : -1, frame);
        check({name, "_code"}, (idx < log_q.size()) ? log_q[idx].code : -1, code);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int f;
        int n;
        total      = 0;
        bad        = 0;
        btn        = 4'b0000;
        vs_manual  = 1'b0;
        vs_man_val = 1'b0;
        rst        = 1'b1;
        #1;
        check("reset_swout", {29'd0, swout}, 32'd0);
        check("reset_active", {31'd0, active}, 32'd0);
        step(3);
        rst = 1'b0;

        // Bounce rejection: three 3-cycle glitches, then a stable press.
        wait_mid();
        f = frame_no;
        log_q.delete();
        repeat (3) begin
            btn = 4'b0001; step(3);
            btn = 4'b0000; step(3);
        end
        btn = 4'b0001;
        wait_mid();
        step(7 * FRAME);
        check("bounce_count", log_q.size(), 4);
        check_log("bounce0", 0, f + 1, 1);
        check_log("bounce1", 1, f + 4, 1);
        check_log("bounce2", 2, f + 6, 1);
        check_log("bounce3", 3, f + 8, 1);
        btn = 4'b0000;
        step(20);

        // Opposite cancel: right + left held for ten frames.
        wait_mid();
        f = frame_no;
        log_q.delete();
        act_seen = 1'b0;
        btn = 4'b0101;
        step(10 * FRAME);
        check("cancel_no_move", log_q.size(), 0);
        check("cancel_no_active", {31'd0, act_seen}, 32'd0);
        btn = 4'b0001;
        wait_mid();
        check("cancel_release_count", log_q.size(), 1);
        check_log("cancel_release", 0, f + 11, 1);
        btn = 4'b0000;
        step(20);

        // Round-robin from reset priority: right + up.
        rst = 1'b1; step(2); rst = 1'b0;
        wait_mid();
        f = frame_no;
        log_q.delete();
        btn = 4'b1001;
        wait_mid();
        step(7 * FRAME);
        check("rr_count", log_q.size(), 4);
        check_log("rr0", 0, f + 1, 1);
        check_log("rr1", 1, f + 4, 4);
        check_log("rr2", 2, f + 6, 1);
        check_log("rr3", 3, f + 8, 4);
        btn = 4'b0000;
        step(20);

        // Release during DELAY.
        wait_mid();
        f = frame_no;
        log_q.delete();
        btn = 4'b0010;
        wait_mid();
        wait_mid();
        check("delay_active_before_release", {31'd0, active}, 32'd1);
        btn = 4'b0000;
        n = 0;
        do begin
            step(1);
            n++;
        end while (active !== 1'b0 && n < 20);
        check("release_latency_ok", {31'd0, (n <= DEB + 3)}, 32'd1);
        wait_mid();
        wait_mid();
        check("release_count", log_q.size(), 1);
        check_log("release0", 0, f + 1, 2);
        step(20);

        // Reset mid-REPEAT, then right priority after release.
        wait_mid();
        btn = 4'b0100;
        step(3 * FRAME);
        n = 0;
        do begin
            step(1);
            n++;
        end while (swout == 3'd0 && n < 2 * FRAME);
        check("repeat_move_seen", {31'd0, (swout != 3'd0)}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_swout_now", {29'd0, swout}, 32'd0);
        check("rst_active_now", {31'd0, active}, 32'd0);
        btn = 4'b1011;
        step(3);
        rst = 1'b0;
        n = 0;
        do begin
            step(1);
            n++;
        end while (swout == 3'd0 && n < 3 * FRAME);
        check("post_rst_wait_ok", {31'd0, (n >= DEB + 2 && n < 3 * FRAME)}, 32'd1);
        check("post_rst_right_first", {29'd0, swout}, 32'd1);
        step(4 * FRAME);
        btn = 4'b0000;
        step(20);

        // Tick alignment with a single one-cycle vsync pulse, then vsync stuck active.
        vs_manual  = 1'b1;
        vs_man_val = 1'b0;
        step(20);
        btn = 4'b0001;
        step(20);
        check("pre_pulse_swout", {29'd0, swout}, 32'd0);
        vs_man_val = 1'b1;
        @(posedge clk);
        #3;
        check("pulse_swout_n1", {29'd0, swout}, 32'd1);
        vs_man_val = 1'b0;
        @(posedge clk);
        #3;
        check("pulse_swout_n2", {29'd0, swout}, 32'd0);
        btn = 4'b0000;
        step(20);
        vs_man_val = 1'b1;
        step(5);
        log_q.delete();
        btn = 4'b0001;
        step(3 * FRAME);
        check("stuck_vsync_no_move", log_q.size(), 0);
        btn = 4'b0000;
        step(20);
        vs_manual = 1'b0;

        // Random holds, glitches and occasional resets.
        for (int it = 0; it < 70; it++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                rst = 1'b1; step(2); rst = 1'b0;
            end else if (r < 6) begin
                btn = 4'($urandom_range(0, 15));
                step(int'($urandom_range(1, 3)));
            end else begin
                btn = 4'($urandom_range(0, 15));
                step(int'($urandom_range(5, 400)));
            end
        end
        btn = 4'b0000;
        step(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
